ib_dispatch_scheduler: RTL and testbench
========================================

// Module: ib_dispatch_scheduler
// PURPOSE
//  Gates dispatch out of the instruction buffer each cycle. Drives the buffer's stall_i
//  when any back-end resource cannot take a full DISPATCH_WIDTH group: active list, issue
//  queue, free physical registers or branch checkpoints. Tracks free branch checkpoints
//  and enforces a post-flush recovery window. Sits between InstructionBuffer and rename.
// PARAMETERS
//  DISPATCH_WIDTH   4    instructions dispatched per fire (matches buffer read ports)
//  BRANCH_COUNT     3    width of branchCount_i
//  NUM_CKPT         4    branch checkpoints available to rename
//  CKPT_LOG         3    width of checkpoint counters; must hold NUM_CKPT
//  AL_LOG           7    active-list free-count width - 1
//  IQ_LOG           5    issue-queue free-count width - 1
//  FREG_LOG         7    free-list count width - 1
//  RECOVER_CYCLES   2    forced-stall cycles after a flush; >=1
// PORTS
//  clk              in   1            clock
//  reset            in   1            synchronous, active-high
//  flush_i          in   1            control mispredict; same flush that clears the buffer
//  instBufferReady_i in  1            buffer holds >= DISPATCH_WIDTH instructions
//  branchCount_i    in   BRANCH_COUNT branches in the current head group
//  alFreeCnt_i      in   AL_LOG+1     free active-list entries
//  iqFreeCnt_i      in   IQ_LOG+1     free issue-queue entries
//  freeRegCnt_i     in   FREG_LOG+1   free physical registers
//  ckptRelease_i    in   CKPT_LOG     checkpoints released by branch resolution this cycle
//  ibStall_o        out  1            to InstructionBuffer stall_i
//  dispatchFire_o   out  1            head group is dispatched this cycle
//  ckptFreeCnt_o    out  CKPT_LOG     registered free-checkpoint count
//  stallCause_o     out  6            [0]bufEmpty [1]AL [2]IQ [3]regs [4]ckpt [5]recover/flush
//  stallCycles_o    out  32           saturating count of resource-stall cycles
//  ckptErr_o        out  1            sticky: release overflow or allocation underflow
// BEHAVIOUR
//  - Reset: state=RUN, ckptFree=NUM_CKPT, stallCycles=0, ckptErr=0; outputs follow.
//  - FSM: RUN, RECOVER. In RUN, flush_i moves to RECOVER with recCnt=RECOVER_CYCLES-1.
//    In RECOVER, recCnt decrements each cycle and the FSM returns to RUN when recCnt==0.
//    A flush during RECOVER reloads recCnt. Flush cycle t => ibStall_o=1 for cycles
//    t..t+RECOVER_CYCLES; first possible fire at t+RECOVER_CYCLES+1.
//  - ok = state==RUN & ~flush_i & instBufferReady_i & alFreeCnt_i>=DW & iqFreeCnt_i>=DW
//    & freeRegCnt_i>=DW & ckptFree>=branchCount_i. All compares are unsigned and
//    zero-extended to the widest operand.
//  - dispatchFire_o=ok; ibStall_o=~ok. Both are combinational, zero latency. This matches
//    the buffer rule that head advances iff ~stall_i & count>=DW.
//  - stallCause_o: combinational, one bit per failing term. Several bits may be set.
//    Bit5 is set in RECOVER or when flush_i=1. All zero when ok=1.
//  - Checkpoint count: next = ckptFree - (fire ? branchCount_i : 0) + ckptRelease_i.
//    Compute at CKPT_LOG+2 bits. If the result > NUM_CKPT, clamp to NUM_CKPT and set
//    ckptErr_o. A negative result is unreachable by the gate; treat it the same way
//    (clamp to 0, set error). Allocate and release in the same cycle net out.
//  - flush_i: ckptFree <= NUM_CKPT (all speculative checkpoints freed); ckptRelease_i is
//    ignored that cycle. ckptErr_o is not cleared.
//  - stallCycles_o increments when ibStall_o & instBufferReady_i & state==RUN & ~flush_i.
//    Saturates at 32'hFFFF_FFFF. Cleared only by reset.
//  - reset has priority over flush_i. Reset mid-RECOVER returns to RUN next cycle.
// STRUCTURE
//  - Shared package: FSM state encoding, stallCause bit indices (CAUSE_BUF..CAUSE_RECOVER).
//  - One sub-module, ib_ckpt_counter: alloc/release/flush inputs; count and err outputs;
//    owns clamp logic. Gate, FSM and stall counter stay in the top level.
// TESTING
//  1 reset; all free counts large, ready=1, branchCount=0 -> fire=1 every cycle,
//    ibStall_o=0, stallCause=0.
//  2 alFreeCnt_i=3 (DW=4) -> ibStall_o=1, cause=6'b000010, stallCycles +1 per cycle;
//    alFreeCnt_i=4 -> fire resumes the same cycle.
//  3 ckptFree=4; fire with branchCount=3 -> next ckptFree=1; next group branchCount=2
//    -> stall, cause bit4; ckptRelease_i=1 -> ckptFree=2, fire.
//  4 flush at cycle 10 with ckptFree=1 -> ibStall_o=1 in cycles 10-12, first fire at 13,
//    ckptFree=4 at 11. Second flush at 11 -> stall through 13, first fire at 14.
//  5 ckptFree=4, ckptRelease_i=2, no fire -> ckptFree stays 4, ckptErr_o=1 and sticky.
//  6 ready=0 with resources free -> no stallCycles increment; stallCycles forced to
//    FFFF_FFFE then 3 stall cycles -> holds at FFFF_FFFF.

Source files
------------

// File: rtl/ib_dispatch_scheduler_pkg.sv
// Shared definitions for the instruction-buffer dispatch scheduler.
// Holds the sizing constants, FSM encoding and stall-cause bit positions.
package ib_dispatch_scheduler_pkg;

    localparam int unsigned DISPATCH_WIDTH = 4;
    localparam int unsigned BRANCH_COUNT   = 3;
    localparam int unsigned NUM_CKPT       = 4;
    localparam int unsigned CKPT_LOG       = 3;
    localparam int unsigned AL_LOG         = 7;
    localparam int unsigned IQ_LOG         = 5;
    localparam int unsigned FREG_LOG       = 7;
    localparam int unsigned RECOVER_CYCLES = 2;

    localparam int unsigned AL_W    = AL_LOG + 1;
    localparam int unsigned IQ_W    = IQ_LOG + 1;
    localparam int unsigned FREG_W  = FREG_LOG + 1;
    localparam int unsigned REC_W   = $clog2(RECOVER_CYCLES + 1);
    localparam int unsigned CAUSE_W = 6;
    localparam int unsigned STALL_W = 32;

    localparam int unsigned CAUSE_BUF     = 0;
    localparam int unsigned CAUSE_AL      = 1;
    localparam int unsigned CAUSE_IQ      = 2;
    localparam int unsigned CAUSE_REGS    = 3;
    localparam int unsigned CAUSE_CKPT    = 4;
    localparam int unsigned CAUSE_RECOVER = 5;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } sched_state_e;

endpackage

// File: rtl/ib_dispatch_scheduler_if.sv
// Scheduler-facing bundle: buffer/back-end status in, stall and dispatch status out.
// master drives the status inputs; slave is the scheduler itself.
interface ib_dispatch_scheduler_if;
    import ib_dispatch_scheduler_pkg::*;

    logic                     flush_i;
    logic                     instBufferReady_i;
    logic [BRANCH_COUNT-1:0]  branchCount_i;
    logic [AL_W-1:0]          alFreeCnt_i;
    logic [IQ_W-1:0]          iqFreeCnt_i;
    logic [FREG_W-1:0]        freeRegCnt_i;
    logic [CKPT_LOG-1:0]      ckptRelease_i;

    logic                     ibStall_o;
    logic                     dispatchFire_o;
    logic [CKPT_LOG-1:0]      ckptFreeCnt_o;
    logic [CAUSE_W-1:0]       stallCause_o;
    logic [STALL_W-1:0]       stallCycles_o;
    logic                     ckptErr_o;

    modport master (
        output flush_i, instBufferReady_i, branchCount_i, alFreeCnt_i,
               iqFreeCnt_i, freeRegCnt_i, ckptRelease_i,
        input  ibStall_o, dispatchFire_o, ckptFreeCnt_o, stallCause_o,
               stallCycles_o, ckptErr_o
    );

    modport slave (
        input  flush_i, instBufferReady_i, branchCount_i, alFreeCnt_i,
               iqFreeCnt_i, freeRegCnt_i, ckptRelease_i,
        output ibStall_o, dispatchFire_o, ckptFreeCnt_o, stallCause_o,
               stallCycles_o, ckptErr_o
    );

endinterface

// File: rtl/ib_dispatch_scheduler_ckpt.sv
// Free branch-checkpoint counter: net allocate/release per cycle, clamped to
// [0, NUM_CKPT] with a sticky error on any clamp; a flush frees every checkpoint.
module ib_ckpt_counter
    import ib_dispatch_scheduler_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_flush,
    input  logic [BRANCH_COUNT-1:0] i_alloc,
    input  logic [CKPT_LOG-1:0]     i_release,
    output logic [CKPT_LOG-1:0]     o_count,
    output logic                    o_err
);

    localparam int unsigned SUM_W = CKPT_LOG + 2;

    logic [CKPT_LOG-1:0] r_count;
    logic                r_err;
    logic [SUM_W-1:0]    w_sum;
    logic                w_under;
    logic                w_over;
    logic [CKPT_LOG-1:0] w_next;

    // Two extra bits: the top one flags a negative result, the other absorbs overflow.
    always_comb begin
        w_sum   = SUM_W'(r_count) - SUM_W'(i_alloc) + SUM_W'(i_release);
        w_under = w_sum[SUM_W-1];
        w_over  = ~w_under & (w_sum > SUM_W'(NUM_CKPT));
        w_next  = w_sum[CKPT_LOG-1:0];
        if (w_under) begin
            w_next = '0;
        end else if (w_over) begin
            w_next = CKPT_LOG'(NUM_CKPT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= CKPT_LOG'(NUM_CKPT);
            r_err   <= 1'b0;
        end else if (i_flush) begin
            r_count <= CKPT_LOG'(NUM_CKPT);
        end else begin
            r_count <= w_next;
            if (w_under | w_over) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_err   = r_err;

endmodule

// File: rtl/ib_dispatch_scheduler.sv
// Dispatch gate between the instruction buffer and rename: stalls the buffer unless every
// back-end resource can take a full group, and holds a fixed recovery window after flush.
module ib_dispatch_scheduler
    import ib_dispatch_scheduler_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    ib_dispatch_scheduler_if.slave bus
);

    localparam int unsigned CMP_W = (CKPT_LOG > BRANCH_COUNT) ? CKPT_LOG : BRANCH_COUNT;

    sched_state_e            r_state;
    logic [REC_W-1:0]        r_rec_cnt;
    logic [STALL_W-1:0]      r_stall_cycles;

    logic [CKPT_LOG-1:0]     w_ckpt_free;
    logic                    w_ckpt_err;
    logic [CAUSE_W-1:0]      w_cause;
    logic                    w_ok;
    logic                    w_stall_cnt_en;
    logic [BRANCH_COUNT-1:0] w_alloc;

    // One cause bit per failing term; dispatch fires only when none are set.
    always_comb begin
        w_cause                = '0;
        w_cause[CAUSE_BUF]     = ~bus.instBufferReady_i;
        w_cause[CAUSE_AL]      = bus.alFreeCnt_i  < AL_W'(DISPATCH_WIDTH);
        w_cause[CAUSE_IQ]      = bus.iqFreeCnt_i  < IQ_W'(DISPATCH_WIDTH);
        w_cause[CAUSE_REGS]    = bus.freeRegCnt_i < FREG_W'(DISPATCH_WIDTH);
        w_cause[CAUSE_CKPT]    = CMP_W'(w_ckpt_free) < CMP_W'(bus.branchCount_i);
        w_cause[CAUSE_RECOVER] = (r_state == ST_RECOVER) | bus.flush_i;
    end

    assign w_ok    = ~|w_cause;
    assign w_alloc = w_ok ? bus.branchCount_i : '0;

    // Recovery window: a flush (re)loads the counter, RUN resumes once it has drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_rec_cnt <= '0;
        end else if (bus.flush_i) begin
            r_state   <= ST_RECOVER;
            r_rec_cnt <= REC_W'(RECOVER_CYCLES - 1);
        end else begin
            case (r_state)
                ST_RECOVER: begin
                    if (r_rec_cnt == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_rec_cnt <= r_rec_cnt - REC_W'(1);
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Only genuine resource stalls count: buffer ready, running, not flushing.
    assign w_stall_cnt_en = ~w_ok & bus.instBufferReady_i & (r_state == ST_RUN) & ~bus.flush_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall_cnt_en & ~&r_stall_cycles) begin
            r_stall_cycles <= r_stall_cycles + STALL_W'(1);
        end
    end

    ib_ckpt_counter u_ckpt (
        .clk       (clk),
        .reset     (reset),
        .i_flush   (bus.flush_i),
        .i_alloc   (w_alloc),
        .i_release (bus.ckptRelease_i),
        .o_count   (w_ckpt_free),
        .o_err     (w_ckpt_err)
    );

    assign bus.dispatchFire_o = w_ok;
    assign bus.ibStall_o      = ~w_ok;
    assign bus.stallCause_o   = w_cause;
    assign bus.ckptFreeCnt_o  = w_ckpt_free;
    assign bus.stallCycles_o  = r_stall_cycles;
    assign bus.ckptErr_o      = w_ckpt_err;

endmodule

// File: tb/tb_ib_dispatch_scheduler.sv
// Directed bench for ib_dispatch_scheduler: a cycle model pushes expected outputs to a
// scoreboard queue each cycle, which is popped and checked against the DUT.
module tb_ib_dispatch_scheduler;
    import ib_dispatch_scheduler_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ib_dispatch_scheduler_if bus ();

    ib_dispatch_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        fire;
        logic        stall;
        logic [5:0]  cause;
        logic [2:0]  ckpt;
        logic [31:0] cyc;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    bit          m_run;
    int          m_rec;
    int          m_ckpt;
    bit          m_err;
    logic [31:0] m_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b1;
        m_rec  = 0;
        m_ckpt = 4;
        m_err  = 1'b0;
        m_cyc  = 32'h0;
    endtask

    task automatic set_defaults();
        bus.flush_i           = 1'b0;
        bus.instBufferReady_i = 1'b1;
        bus.branchCount_i     = 3'd0;
        bus.alFreeCnt_i       = 8'd100;
        bus.iqFreeCnt_i       = 6'd20;
        bus.freeRegCnt_i      = 8'd100;
        bus.ckptRelease_i     = 3'd0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle(input string tag);
        exp_t       e;
        exp_t       o;
        logic [5:0] c;
        bit         ok;
        bit         cnt_en;
        int         nxt;
        #1;
        c[0] = !bus.instBufferReady_i;
        c[1] = int'(bus.alFreeCnt_i) < 4;
        c[2] = int'(bus.iqFreeCnt_i) < 4;
        c[3] = int'(bus.freeRegCnt_i) < 4;
        c[4] = m_ckpt < int'(bus.branchCount_i);
        c[5] = !m_run || bus.flush_i;
        ok   = (c == 6'b0);
        e.fire  = ok;
        e.stall = !ok;
        e.cause = c;
        e.ckpt  = 3'(m_ckpt);
        e.cyc   = m_cyc;
        e.err   = m_err;
        sb.push_back(e);
        o = sb.pop_front();
        chk({tag, ".fire"},  32'(bus.dispatchFire_o), 32'(o.fire));
        chk({tag, ".stall"}, 32'(bus.ibStall_o),      32'(o.stall));
        chk({tag, ".cause"}, 32'(bus.stallCause_o),   32'(o.cause));
        chk({tag, ".ckpt"},  32'(bus.ckptFreeCnt_o),  32'(o.ckpt));
        chk({tag, ".cyc"},   bus.stallCycles_o,       o.cyc);
        chk({tag, ".err"},   32'(bus.ckptErr_o),      32'(o.err));
        cnt_en = !ok && bus.instBufferReady_i && m_run && !bus.flush_i;
        @(posedge clk);
        if (cnt_en && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
        if (bus.flush_i) begin
            m_run  = 1'b0;
            m_rec  = RECOVER_CYCLES - 1;
            m_ckpt = 4;
        end else begin
            if (!m_run) begin
                if (m_rec == 0) m_run = 1'b1;
                else            m_rec = m_rec - 1;
            end
            nxt = m_ckpt - (ok ? int'(bus.branchCount_i) : 0) + int'(bus.ckptRelease_i);
            if (nxt > 4) begin
                nxt   = 4;
                m_err = 1'b1;
            end else if (nxt < 0) begin
                nxt   = 0;
                m_err = 1'b1;
            end
            m_ckpt = nxt;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        set_defaults();
        do_reset();

        // Unconstrained resources: fire every cycle
        cycle("rst");
        cycle("free1");
        cycle("free2");

        // Active-list boundary at DW-1 / DW
        bus.alFreeCnt_i = 8'd3;
        cycle("al3_a");
        cycle("al3_b");
        cycle("al3_c");
        bus.alFreeCnt_i = 8'd4;
        cycle("al4");
        bus.alFreeCnt_i = 8'd100;
        bus.iqFreeCnt_i = 6'd3;
        bus.freeRegCnt_i = 8'd2;
        cycle("iq_reg");
        bus.iqFreeCnt_i = 6'd4;
        bus.freeRegCnt_i = 8'd4;
        cycle("iq_reg_ok");

        // Checkpoint allocation, shortage and release
        bus.branchCount_i = 3'd3;
        cycle("br3");
        bus.branchCount_i = 3'd2;
        cycle("br2_short");
        bus.ckptRelease_i = 3'd1;
        cycle("br2_rel");
        bus.ckptRelease_i = 3'd0;
        cycle("br2_fire");
        bus.branchCount_i = 3'd0;
        bus.ckptRelease_i = 3'd1;
        cycle("rel1");
        bus.ckptRelease_i = 3'd0;

        // Flush with one free checkpoint and a release that must be ignored
        bus.flush_i = 1'b1;
        bus.ckptRelease_i = 3'd2;
        cycle("flush_t");
        bus.flush_i = 1'b0;
        bus.ckptRelease_i = 3'd0;
        cycle("flush_t1");
        cycle("flush_t2");
        cycle("flush_t3");

        // Back-to-back flushes extend the window
        bus.flush_i = 1'b1;
        cycle("dflush_t");
        cycle("dflush_t1");
        bus.flush_i = 1'b0;
        cycle("dflush_t2");
        cycle("dflush_t3");
        cycle("dflush_t4");

        // Release overflow with no dispatch: clamp and sticky error
        bus.instBufferReady_i = 1'b0;
        bus.ckptRelease_i = 3'd2;
        cycle("ovf");
        bus.ckptRelease_i = 3'd0;
        cycle("ovf_hold");
        bus.instBufferReady_i = 1'b1;
        cycle("ovf_sticky");

        // Buffer not ready: stall without counting; then saturation of the counter
        bus.instBufferReady_i = 1'b0;
        cycle("notready");
        bus.instBufferReady_i = 1'b1;
        bus.alFreeCnt_i = 8'd3;
        force dut.r_stall_cycles = 32'hFFFF_FFFE;
        release dut.r_stall_cycles;
        m_cyc = 32'hFFFF_FFFE;
        cycle("sat_a");
        cycle("sat_b");
        cycle("sat_c");
        cycle("sat_d");
        bus.alFreeCnt_i = 8'd100;

        // Reset in the middle of recovery
        bus.flush_i = 1'b1;
        cycle("pre_rst_flush");
        bus.flush_i = 1'b0;
        do_reset();
        cycle("post_rst");
        bus.branchCount_i = 3'd7;
        cycle("br7_short");
        bus.branchCount_i = 3'd0;
        cycle("post_rst_fire");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
